// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences reset of a PLL and release of the downstream clock domain.
//
// Drives pll_rst for a fixed pulse, waits for lock with a timeout, requires a stable lock
// window before releasing sys_rst, retries failed lock attempts and latches FAULT after
// MAX_RETRIES consecutive failures. In RUN, loss of lock or relock_req restarts the sequence.
//
// Ports:
//   refclk      in   sole clock (free-running PLL reference)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   relock_req  in   single-cycle request to re-run the sequence (honoured only in RUN)
//   pll_rst     out  active-high PLL reset
//   sys_rst     out  active-high reset to the processor clock domain
//   ready       out  high only in RUN
//   fault       out  high only in FAULT
//   retry_cnt   out  failed attempts since last rst or last RUN entry
//   state       out  0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT
//
// Build option: define PLL_SEQ_LOCK_FILTER_EN to require 4 consecutive lock=0 samples
// before RUN treats lock as lost; otherwise a single lock=0 sample is a loss.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int unsigned MaxAB     = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                        RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MaxCycles = (MaxAB > LOCK_TIMEOUT_CYCLES) ?
                                        MaxAB : LOCK_TIMEOUT_CYCLES;
    // Counter only ever reaches MaxCycles-1 before a state change clears it.
    localparam int unsigned CntW      = $clog2(MaxCycles);

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        retry_q, retry_d;
    logic              sync1_q, sync2_q;
    logic              pll_rst_q, sys_rst_q, ready_q, fault_q;
    logic              lock;
    logic              lock_lost;

    assign lock = sync2_q;

`ifdef PLL_SEQ_LOCK_FILTER_EN
    logic [1:0] drop_q, drop_d;

    // Fourth consecutive low sample in RUN is the loss event.
    assign lock_lost = !lock && (drop_q == 2'd3);

    always_comb begin
        drop_d = 2'd0;
        if (state_q == StRun && state_d == StRun && !lock) begin
            drop_d = drop_q + 2'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            drop_q <= 2'd0;
        end else begin
            drop_q <= drop_d;
        end
    end
`else
    assign lock_lost = !lock;
`endif

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            StResetPll: begin
                if (cnt_q == CntW'(RST_PULSE_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a timeout landing in the same cycle.
                if (lock) begin
                    state_d = StStabilize;
                end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_d == 4'(MAX_RETRIES)) ? StFault : StResetPll;
                end
            end
            StStabilize: begin
                if (!lock) begin
                    state_d = StWaitLock;
                end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = StRun;
                    retry_d = 4'd0;
                end
            end
            StRun: begin
                if (lock_lost || relock_req) state_d = StResetPll;
            end
            StFault: state_d = StFault;
            default: state_d = StResetPll;
        endcase

        // Counter is held at zero in the untimed states so it can never wrap.
        if (state_d != state_q || state_q == StRun || state_q == StFault) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= StResetPll;
            cnt_q     <= '0;
            retry_q   <= 4'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            // Outputs decoded from next state so they line up with state_q.
            unique case (state_d)
                StResetPll:  begin pll_rst_q <= 1'b1; sys_rst_q <= 1'b1;
                                   ready_q <= 1'b0; fault_q <= 1'b0; end
                StWaitLock,
                StStabilize: begin pll_rst_q <= 1'b0; sys_rst_q <= 1'b1;
                                   ready_q <= 1'b0; fault_q <= 1'b0; end
                StRun:       begin pll_rst_q <= 1'b0; sys_rst_q <= 1'b0;
                                   ready_q <= 1'b1; fault_q <= 1'b0; end
                StFault:     begin pll_rst_q <= 1'b1; sys_rst_q <= 1'b1;
                                   ready_q <= 1'b0; fault_q <= 1'b1; end
                default:     begin pll_rst_q <= 1'b1; sys_rst_q <= 1'b1;
                                   ready_q <= 1'b0; fault_q <= 1'b0; end
            endcase
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus pushes hand-computed output events
// (cycle, state, outputs, retry count); the monitor pops one on every change of the
// output tuple and compares it.
module tb_pll_reset_sequencer;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [3:0] retry;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b1;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [3:0] retry_cnt;
    logic [2:0] dut_state;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (3)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .state     (dut_state)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    // Output levels per state are written out by hand from the state descriptions.
    task automatic push(input int c, input logic [2:0] st, input logic [3:0] retry);
        exp_t e;
        e.cyc = c;
        e.st = st;
        e.retry = retry;
        case (st)
            S_RST:   begin e.pll_rst = 1; e.sys_rst = 1; e.ready = 0; e.fault = 0; end
            S_RUN:   begin e.pll_rst = 0; e.sys_rst = 0; e.ready = 1; e.fault = 0; end
            S_FLT:   begin e.pll_rst = 1; e.sys_rst = 1; e.ready = 0; e.fault = 1; end
            default: begin e.pll_rst = 0; e.sys_rst = 1; e.ready = 0; e.fault = 0; end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    // Monitor: any change of the output tuple is one DUT event.
    logic [11:0] prev_t = 12'hxxx;
    always @(negedge refclk) begin
        logic [11:0] cur_t;
        exp_t e;
        cur_t = {dut_state, pll_rst, sys_rst, ready, fault, retry_cnt};
        if (cur_t !== prev_t) begin
            prev_t = cur_t;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: cyc=%0d state=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d, required no change",
                         cyc, dut_state, pll_rst, sys_rst, ready, fault, retry_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.st !== dut_state || e.pll_rst !== pll_rst ||
                    e.sys_rst !== sys_rst || e.ready !== ready || e.fault !== fault ||
                    e.retry !== retry_cnt) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d st=%0d pr=%b sr=%b rdy=%b flt=%b rc=%0d required cyc=%0d st=%0d pr=%b sr=%b rdy=%b flt=%b rc=%0d",
                             cyc, dut_state, pll_rst, sys_rst, ready, fault, retry_cnt,
                             e.cyc, e.st, e.pll_rst, e.sys_rst, e.ready, e.fault, e.retry);
                end
            end
        end
    end

    initial begin
        // Reset values, then lock present from release: RUN 13 cycles after release.
        push(1, S_RST, 0);
        push(7, S_WAIT, 0);
        push(8, S_STAB, 0);
        push(16, S_RUN, 0);
        wait_until(3);
        rst = 1'b0;

        // Two-cycle lock drop in RUN.
`ifndef PLL_SEQ_LOCK_FILTER_EN
        push(23, S_RST, 0);
        push(27, S_WAIT, 0);
        push(28, S_STAB, 0);
        push(36, S_RUN, 0);
`endif
        wait_until(20);
        pll_locked = 1'b0;
        wait_until(22);
        pll_locked = 1'b1;

        // relock_req and lock loss seen in the same cycle: one 4-cycle RESET_PLL.
        push(41, S_RST, 0);
        push(45, S_WAIT, 0);
        push(46, S_STAB, 0);
        push(54, S_RUN, 0);
        wait_until(38);
        pll_locked = 1'b0;
        wait_until(40);
        relock_req = 1'b1;
        wait_until(41);
        relock_req = 1'b0;
        pll_locked = 1'b1;

        // One-sample drop at stable count 5 returns to WAIT_LOCK without a failure.
        push(61, S_RST, 0);
        push(65, S_WAIT, 0);
        push(66, S_STAB, 0);
        push(72, S_WAIT, 0);
        push(73, S_STAB, 0);
        push(81, S_RUN, 0);
        wait_until(60);
        relock_req = 1'b1;
        wait_until(61);
        relock_req = 1'b0;
        wait_until(69);
        pll_locked = 1'b0;
        wait_until(70);
        pll_locked = 1'b1;

        // Lock never returns: three timeouts end in FAULT, which ignores lock and relock.
        push(88, S_RST, 0);
        push(92, S_WAIT, 0);
        push(124, S_RST, 1);
        push(128, S_WAIT, 1);
        push(160, S_RST, 2);
        push(164, S_WAIT, 2);
        push(196, S_FLT, 3);
        wait_until(85);
        pll_locked = 1'b0;
        wait_until(87);
        relock_req = 1'b1;
        wait_until(88);
        relock_req = 1'b0;
        wait_until(200);
        pll_locked = 1'b1;
        wait_until(205);
        relock_req = 1'b1;
        wait_until(206);
        relock_req = 1'b0;

        // rst clears FAULT; sequence restarts on release.
        push(221, S_RST, 0);
        push(228, S_WAIT, 0);
        push(229, S_STAB, 0);
        push(237, S_RUN, 0);
        wait_until(220);
        rst = 1'b1;
        wait_until(224);
        rst = 1'b0;

        // One timeout, rst in WAIT_LOCK, then lock arriving on the timeout cycle.
        push(241, S_RST, 0);
        push(245, S_WAIT, 0);
        push(277, S_RST, 1);
        push(281, S_WAIT, 1);
        push(286, S_RST, 0);
        push(294, S_WAIT, 0);
        push(326, S_STAB, 0);
        push(334, S_RUN, 0);
        wait_until(240);
        pll_locked = 1'b0;
        relock_req = 1'b1;
        wait_until(241);
        relock_req = 1'b0;
        wait_until(285);
        rst = 1'b1;
        wait_until(290);
        rst = 1'b0;
        wait_until(323);
        pll_locked = 1'b1;

        wait_until(345);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none, required cyc=%0d st=%0d rc=%0d",
                     e.cyc, e.st, e.retry);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
